// File: rtl/pc_fetch_if.sv
// Control/ROM-side bundle of the PC fetch sequencer: next-PC controls, ROM data in,
// PC/status out. state_dbg mirrors the sequencer's FSM state for observation.
interface pc_fetch_if;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [31:0] imm;
    logic [25:0] jaddr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        rom_rd;
    logic        halted;
    logic        addr_err;
    logic [31:0] instret;
    logic [1:0]  state_dbg;

    // No valid/ready handshake: every input is sampled at each rising clock edge in RUN,
    // and every output is a registered value (or pc+4) that is stable for the whole cycle.
    modport slave (
        input  PCWre, PCSrc, imm, jaddr, instr,
        output pc, pc4, rom_rd, halted, addr_err, instret, state_dbg
    );

    modport master (
        output PCWre, PCSrc, imm, jaddr, instr,
        input  pc, pc4, rom_rd, halted, addr_err, instret, state_dbg
    );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer (BOOT/RUN/HALT/ERR) feeding the ROM.
// Optional macro PC_RANGE_CHECK_EN traps misaligned or out-of-ROM next-PC values into ERR.
module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 100
) (
    input logic       CLK,
    input logic       RST,
    pc_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;
    localparam logic [31:0] PC_MAX     = 32'(ROM_BYTES - 4);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        advance;
    logic        next_bad;
    logic        unused_ok;

    assign pc4 = pc_q + 32'd4;

    always_comb begin
        next_pc = pc_q;
        case (bus.PCSrc)
            2'b00:   next_pc = pc4;
            2'b01:   next_pc = pc4 + {bus.imm[29:0], 2'b00};
            2'b10:   next_pc = {pc4[31:28], bus.jaddr, 2'b00};
            default: next_pc = pc_q;
        endcase
    end

    assign advance  = bus.PCWre && (bus.PCSrc != 2'b11);
    assign next_bad = (next_pc[1:0] != 2'b00) || (next_pc > PC_MAX);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                // Halt opcode wins over any PC update requested in the same cycle.
                if (bus.instr == HALT_INSTR) begin
                    state_d = ST_HALT;
                end else if (advance) begin
`ifdef PC_RANGE_CHECK_EN
                    if (next_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                    end
`else
                    pc_d      = {next_pc[31:2], 2'b00};
                    instret_d = instret_q + 32'd1;
`endif
                end
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc4       = pc4;
    assign bus.rom_rd    = (state_q != ST_RUN);
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.instret   = instret_q;
    assign bus.state_dbg = state_q;

`ifdef PC_RANGE_CHECK_EN
    assign bus.addr_err = (state_q == ST_ERR);
    assign unused_ok    = ^bus.imm[31:30];
`else
    assign bus.addr_err = 1'b0;
    assign unused_ok    = ^{bus.imm[31:30], next_bad};
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized stimulus
// compared against a behavioural model of the fetch sequencer.
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned ROM_BYTES = 100;
    localparam logic [31:0] HALT_OP   = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: mode 0 = boot, 1 = running, 2 = halted, 3 = address error.
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    int          m_mode;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(RESET_PC), .ROM_BYTES(ROM_BYTES)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_edge();
        logic [31:0] tgt;
        if (!rst) begin
            m_pc = RESET_PC; m_instret = 0; m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (bus.instr == HALT_OP) begin
                m_mode = 2;
            end else if (bus.PCWre && bus.PCSrc != 2'd3) begin
                if (bus.PCSrc == 2'd0)      tgt = m_pc + 4;
                else if (bus.PCSrc == 2'd1) tgt = m_pc + 4 + bus.imm * 4;
                else                        tgt = ((m_pc + 4) & 32'hF000_0000) | ({6'd0, bus.jaddr} * 4);
`ifdef PC_RANGE_CHECK_EN
                if ((tgt % 4) != 0 || tgt > ROM_BYTES - 4) begin
                    m_mode = 3;
                end else begin
                    m_pc = tgt; m_instret = m_instret + 1;
                end
`else
                m_pc = tgt & 32'hFFFF_FFFC; m_instret = m_instret + 1;
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] imm_v,
                         input logic [25:0] ja, input logic [31:0] ins);
        bus.PCWre = we; bus.PCSrc = src; bus.imm = imm_v; bus.jaddr = ja; bus.instr = ins;
    endtask

    task automatic test_reset();
        drive(1'b1, 2'd0, 32'd0, 26'd0, 32'd0);
        rst = 1'b0;
        step(); step();
        n_checks++; if (bus.pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.pc, RESET_PC); end
        n_checks++; if (bus.rom_rd !== 1'b1) begin n_fail++; $display("FAIL reset_rom_rd: got %b expected 1", bus.rom_rd); end
        n_checks++; if (bus.halted !== 1'b0 || bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b expected 00", bus.halted, bus.addr_err); end
        n_checks++; if (bus.instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret: got %h expected 0", bus.instret); end
        rst = 1'b1;
        step();
        n_checks++; if (bus.rom_rd !== 1'b0) begin n_fail++; $display("FAIL boot_rom_rd: got %b expected 0", bus.rom_rd); end
        n_checks++; if (bus.pc !== RESET_PC) begin n_fail++; $display("FAIL boot_pc_held: got %h expected %h", bus.pc, RESET_PC); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 2'd0, 32'd0, 26'd0, 32'd0);
            step();
            n_checks++; if (bus.pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc: got %h expected %h", bus.pc, 32'(4 * i)); end
            n_checks++; if (bus.pc4 !== bus.pc + 32'd4) begin n_fail++; $display("FAIL seq_pc4: got %h expected %h", bus.pc4, bus.pc + 32'd4); end
        end
        n_checks++; if (bus.instret !== 32'd3) begin n_fail++; $display("FAIL seq_instret: got %h expected 3", bus.instret); end
    endtask

    task automatic test_branch_jump();
        drive(1'b1, 2'd1, 32'hFFFF_FFFE, 26'd0, 32'd0);
        step();
        n_checks++; if (bus.pc !== 32'd8) begin n_fail++; $display("FAIL branch_back_12: got %h expected 8", bus.pc); end
        step();
        n_checks++; if (bus.pc !== 32'd4) begin n_fail++; $display("FAIL branch_back_8: got %h expected 4", bus.pc); end
        drive(1'b1, 2'd2, 32'd0, 26'h5, 32'd0);
        step();
        n_checks++; if (bus.pc !== 32'h14) begin n_fail++; $display("FAIL jump: got %h expected 14", bus.pc); end
        n_checks++; if (bus.instret !== 32'd6) begin n_fail++; $display("FAIL bj_instret: got %h expected 6", bus.instret); end
    endtask

    task automatic test_stall();
        drive(1'b0, 2'd1, 32'd7, 26'h3F, 32'd0);
        step(); step();
        drive(1'b1, 2'd3, 32'd7, 26'h3F, 32'd0);
        step();
        n_checks++; if (bus.pc !== 32'h14) begin n_fail++; $display("FAIL stall_pc: got %h expected 14", bus.pc); end
        n_checks++; if (bus.instret !== 32'd6) begin n_fail++; $display("FAIL stall_instret: got %h expected 6", bus.instret); end
    endtask

    task automatic test_halt();
        drive(1'b1, 2'd2, 32'd0, 26'h3, 32'd0);
        step();
        drive(1'b1, 2'd0, 32'd0, 26'd0, HALT_OP);
        step();
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b expected 1", bus.halted); end
        n_checks++; if (bus.pc !== 32'd12) begin n_fail++; $display("FAIL halt_pc: got %h expected c", bus.pc); end
        n_checks++; if (bus.rom_rd !== 1'b1) begin n_fail++; $display("FAIL halt_rom_rd: got %b expected 1", bus.rom_rd); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'($urandom_range(0, 2)), $urandom, 26'($urandom), 32'd0);
            step();
        end
        n_checks++; if (bus.halted !== 1'b1 || bus.pc !== 32'd12 || bus.instret !== 32'd7) begin
            n_fail++; $display("FAIL halt_sticky: got h=%b pc=%h ir=%h expected h=1 pc=c ir=7", bus.halted, bus.pc, bus.instret);
        end
        rst = 1'b0;
        step();
        n_checks++; if (bus.pc !== 32'd0 || bus.halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset: got pc=%h h=%b expected pc=0 h=0", bus.pc, bus.halted);
        end
        rst = 1'b1;
        drive(1'b1, 2'd0, 32'd0, 26'd0, 32'd0);
        step();
    endtask

    task automatic test_range();
        rst = 1'b0;
        drive(1'b1, 2'd0, 32'd0, 26'd0, 32'd0);
        step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 23; i++) step();
        n_checks++; if (bus.pc !== 32'd92) begin n_fail++; $display("FAIL range_pre: got %h expected 5c", bus.pc); end
        step();
        n_checks++; if (bus.pc !== 32'd96 || bus.addr_err !== 1'b0) begin
            n_fail++; $display("FAIL range_last_legal: got pc=%h e=%b expected pc=60 e=0", bus.pc, bus.addr_err);
        end
        step();
`ifdef PC_RANGE_CHECK_EN
        n_checks++; if (bus.pc !== 32'd96 || bus.addr_err !== 1'b1 || bus.rom_rd !== 1'b1) begin
            n_fail++; $display("FAIL range_trap: got pc=%h e=%b rd=%b expected pc=60 e=1 rd=1", bus.pc, bus.addr_err, bus.rom_rd);
        end
`else
        n_checks++; if (bus.pc !== 32'd100 || bus.addr_err !== 1'b0) begin
            n_fail++; $display("FAIL range_nocheck: got pc=%h e=%b expected pc=64 e=0", bus.pc, bus.addr_err);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] mag;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 24) != 0);
            mag = $urandom_range(1, 16);
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? mag : 32'd0 - mag,
                  26'($urandom),
                  ($urandom_range(0, 29) == 0) ? HALT_OP : $urandom);
            step();
            n_checks++; if (bus.pc !== m_pc || bus.pc4 !== m_pc + 32'd4) begin
                n_fail++; $display("FAIL rand_pc[%0d]: got pc=%h pc4=%h expected pc=%h pc4=%h", i, bus.pc, bus.pc4, m_pc, m_pc + 32'd4);
            end
            n_checks++; if (bus.instret !== m_instret) begin
                n_fail++; $display("FAIL rand_instret[%0d]: got %h expected %h", i, bus.instret, m_instret);
            end
            n_checks++; if (bus.rom_rd !== (m_mode != 1) || bus.halted !== (m_mode == 2) || bus.addr_err !== (m_mode == 3)) begin
                n_fail++; $display("FAIL rand_status[%0d]: got rd=%b h=%b e=%b expected mode %0d", i, bus.rom_rd, bus.halted, bus.addr_err, m_mode);
            end
        end
    endtask

    initial begin
        m_pc = RESET_PC; m_instret = 0; m_mode = 0;
        drive(1'b0, 2'd0, 32'd0, 26'd0, 32'd0);
        #1;
        test_reset();
        test_sequential();
        test_branch_jump();
        test_stall();
        test_halt();
        test_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch sequencer for the single-cycle CPU. Holds the PC and selects the next PC: sequential, branch or jump. Drives the byte address and active-low read enable of the instruction ROM, and watches the returned instruction word for the halt opcode. Sits directly upstream of the instruction ROM and feeds its `addr`/`rd` inputs.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- `ROM_BYTES`, default 100: size of the instruction ROM in bytes; used by the range check.
- `CLK` input, 1: the single clock. All state updates on its rising edge.
- `RST` input, 1: reset, synchronous, active-low. 0 at a rising edge resets the block.
- `PCWre` input, 1: PC write enable. 0 stalls the PC for that cycle.
- `PCSrc` input, 2: next-PC select. 00 = PC+4; 01 = PC+4+(imm<<2); 10 = {pc4[31:28], jaddr, 2'b00}; 11 = hold.
- `imm` input, 32: sign-extended branch offset, in words.
- `jaddr` input, 26: jump target field.
- `instr` input, 32: instruction word returned by the ROM (ROM `dataOut`).
- `pc` output, 32: current PC; wired to ROM `addr`.
- `pc4` output, 32: pc+4, combinational.
- `rom_rd` output, 1: ROM read enable, active-low (0 = read).
- `halted` output, 1: 1 while in HALT.
- `addr_err` output, 1: 1 while in ERR.
- `instret` output, 32: count of PC advances since reset.

## Operation
- State machine with states BOOT, RUN, HALT, ERR.
- BOOT: entered on reset. pc=RESET_PC, rom_rd=1. Unconditionally goes to RUN after one cycle, which gives the ROM one idle cycle.
- RUN: rom_rd=0.
  - If `instr`==32'hFC00_0000 (opcode 6'b111111), go to HALT. The PC does not update on that edge.
  - Otherwise, if PCWre=1 and PCSrc≠11, load pc with next_pc and increment instret.
  - If PCWre=0 or PCSrc=11, pc and instret hold.
- HALT: rom_rd=1, pc frozen, halted=1. Exit only through reset.
- ERR: rom_rd=1, pc frozen, addr_err=1. Exit only through reset. Reachable only with the configuration macro defined.
- Arithmetic:
  - All address arithmetic is 32-bit unsigned and wraps modulo 2^32.
  - The branch target is pc4 + {imm[29:0],2'b00}.
  - There is no overflow flag.
- instret wraps from 32'hFFFF_FFFF to 0.
- Halt detection has priority over PCWre and PCSrc in the same cycle.
- Reset has priority over everything, in any state and at any point of an update.

## Timing
- Reset values: pc=RESET_PC, rom_rd=1, halted=0, addr_err=0, instret=0, state=BOOT.
- First ROM read (rom_rd=0) happens in the cycle after RST is released.
- pc changes one cycle after the edge at which PCWre/PCSrc were sampled. pc4 follows pc combinationally.
- `instr` is assumed valid within the same cycle as `pc` (the ROM is combinational). It is sampled at the rising edge.
- halted and addr_err assert on the edge that enters their state. No combinational path from `instr` to any output.

## Configuration
- `PC_RANGE_CHECK_EN`:
  - Defined: in RUN, an update whose next_pc has next_pc[1:0]≠0 or next_pc > ROM_BYTES-4 moves to ERR instead of loading. pc keeps its old value and instret does not increment.
  - Undefined: no check. next_pc is loaded with bits [1:0] forced to 00, and the ERR state is never entered (addr_err tied 0).

## Test plan
- Reset/boot: RST=0 for 2 cycles, then 1. Expect pc=0 and rom_rd=1 in the first cycle after release, rom_rd=0 in the next; instret=0.
- Sequential: PCWre=1, PCSrc=00 for 3 edges. Expect pc 0→4→8→12, instret=3.
- Branch and jump:
  - At pc=8, PCSrc=01, imm=32'hFFFF_FFFE → pc=4.
  - Then PCSrc=10, jaddr=26'h5 → pc=32'h14.
- Stall: PCWre=0 for 2 edges, then PCSrc=11 for 1 edge. pc and instret unchanged throughout.
- Halt: instr=32'hFC00_0000 at pc=12 with PCWre=1.
  - Expect halted=1 next cycle, pc stays 12, rom_rd=1.
  - Pulse RST=0 → pc=0, halted=0.
- Range check (macro defined, ROM_BYTES=100): at pc=92, PCSrc=00 → pc=96, legal. At pc=96, PCSrc=00 → addr_err=1, pc stays 96. With the macro undefined, the same step gives pc=100 and addr_err=0.
